// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and the Decode pipeline register.
// Circular buffer of {instr, pc, pc+4} triples, cleared on a taken branch/jump.
module fetch_queue #(
  parameter int          XLEN  = 32,
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [XLEN-1:0]            enq_instr,
  input  logic [XLEN-1:0]            enq_pc,
  input  logic [XLEN-1:0]            enq_pcplus4,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [XLEN-1:0]            deq_instr,
  output logic [XLEN-1:0]            deq_pc,
  output logic [XLEN-1:0]            deq_pcplus4,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 3 * XLEN;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [EW-1:0] storage [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] occupancy;
  logic          enq_fire;
  logic          deq_fire;
  logic [EW-1:0] head_entry;

  // Ready/valid come from registered occupancy only, so no comb path crosses the queue.
  assign enq_ready = (occupancy != FULL);
  assign deq_valid = (occupancy != '0);
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & deq_ready;
  assign count     = occupancy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      if (enq_fire) tail <= tail + PW'(1);
      if (deq_fire) head <= head + PW'(1);
      case ({enq_fire, deq_fire})
        2'b10:   occupancy <= occupancy + CW'(1);
        2'b01:   occupancy <= occupancy - CW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Storage is deliberately not reset; the empty-forcing below hides stale contents.
  always_ff @(posedge clk) begin
    if (enq_fire && !flush) begin
      storage[tail] <= {enq_instr, enq_pc, enq_pcplus4};
    end
  end

  assign head_entry = storage[head];

  always_comb begin
    deq_instr   = XLEN'(NOP);
    deq_pc      = '0;
    deq_pcplus4 = '0;
    if (deq_valid) begin
      deq_instr   = head_entry[3*XLEN-1:2*XLEN];
      deq_pc      = head_entry[2*XLEN-1:XLEN];
      deq_pcplus4 = head_entry[XLEN-1:0];
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch queue between fetch_unit (upstream) and the Decode pipeline register (downstream) of the 5-stage RV32I core.
- Buffers fetched {instruction, PC, PC+4} triples so fetch can keep running while Decode stalls.
- Flushes on a taken branch or jump resolved in Execute.
- Holds DEPTH entries as a circular buffer with valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, width of instruction, PC and PC+4 fields.
- DEPTH, 4, number of entries; power of two, at least 2.
- NOP, 32'h00000013, value driven on deq_instr when the queue is empty (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- flush  in  1  PCSrc from Execute; synchronous clear of all entries.
- enq_valid  in  1  fetch presents a valid triple.
- enq_ready  out  1  queue can accept an entry this cycle.
- enq_instr  in  XLEN  InstrF.
- enq_pc  in  XLEN  pcF.
- enq_pcplus4  in  XLEN  PCPlus4F.
- deq_valid  out  1  head entry valid.
- deq_ready  in  1  Decode consumes the head this cycle (i.e. not stalled).
- deq_instr  out  XLEN  head instruction; NOP when empty.
- deq_pc  out  XLEN  head PC; 0 when empty.
- deq_pcplus4  out  XLEN  head PC+4; 0 when empty.
- count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- State: head pointer, tail pointer (each clog2(DEPTH) bits, wrap modulo DEPTH), count register, DEPTH x 3*XLEN storage array. Storage is not reset.
- Reset (reset=0, asynchronous): head=0, tail=0, count=0. Outputs: deq_valid=0, deq_instr=NOP, deq_pc=0, deq_pcplus4=0, count=0, enq_ready=1. Release is sampled on the next rising clk.
- enq_ready = (count != DEPTH). It depends only on registered state and never on deq_ready, so there is no combinational ready path through the queue.
- deq_valid = (count != 0). Data outputs are a mux of storage[head], forced to NOP/0/0 when count==0.
- Enqueue fires when enq_valid & enq_ready: write storage[tail], tail <= tail+1.
- Dequeue fires when deq_valid & deq_ready: head <= head+1.
- count update: +1 on enqueue only, -1 on dequeue only, unchanged when both fire or neither fires.
- Latency: an entry enqueued at edge N appears on deq_* after edge N, i.e. it is visible in cycle N+1. There is no same-cycle bypass when empty.
- Full (count==DEPTH): enq_ready=0, and enq_valid is ignored even if a dequeue fires the same cycle. The freed slot is advertised in the next cycle.
- Empty (count==0): deq_ready is ignored, and head, tail and count are unchanged by it.
- Wrap-around: pointers roll from DEPTH-1 to 0. Ordering is strictly FIFO across the wrap.
- flush=1 at an edge: head<=0, tail<=0, count<=0. Flush overrides any enqueue or dequeue in the same cycle: the entry being enqueued is discarded, and the dequeue has no effect beyond the clear.
- After flush, deq_valid=0 in the next cycle. An enqueue in the cycle after flush is accepted normally, so the branch-target instruction enters at slot 0.
- flush while reset=0: reset dominates.
- Reset asserted mid-operation: all entries are lost immediately and outputs go to their reset values without waiting for clk.
- No X propagation: deq_* never expose uninitialised storage because of the count==0 forcing.

Test Plan:
- Reset, then enqueue pcs 0x00,0x04,0x08 with instrs 0x00500113,0x00C00193,0xFF718393 and deq_ready=0 -> count=3, deq_pc=0x00, deq_instr=0x00500113, enq_ready=1.
- Continue to 4 entries (pc 0x0C), then hold enq_valid=1 with pc 0x10 -> enq_ready=0, count stays 4, the pc 0x10 entry is not stored. Then deq_ready=1 -> outputs pc 0x00,0x04,0x08,0x0C in order, deq_pcplus4=pc+4.
- Simultaneous enq+deq at count=2 for 6 cycles, pcs 0x00..0x1C -> count stays 2, dequeued sequence is strictly ascending, pointers wrap with no loss or duplication.
- With count=3, assert flush together with enq_valid (pc 0x14) and deq_ready -> next cycle count=0, deq_valid=0, deq_instr=0x00000013. Then enqueue pc 0x24 -> deq_pc=0x24 the following cycle.
- Empty queue with deq_ready=1 for 3 cycles -> count=0, deq_valid=0, deq_pc=0, no pointer movement (a later single enqueue is dequeued correctly).
- With count=2, drive reset=0 between clock edges -> count=0, deq_valid=0, deq_instr=NOP immediately, before the next rising edge.
